and_tree_feeder: RTL and testbench
==================================

Name: and_tree_feeder

Overview:
- Upstream stage of the and_tree reduction.
- Collects a serial stream of W-bit chunks into one N-bit vector x[0:N-1] and presents it to and_tree with a valid/ready handshake.
- Short frames are padded with 1s (the AND identity), so the downstream reduction result is unaffected by missing bits.
- Holds each completed vector stable until the consumer accepts it.

Parameters:
N, 8, width of assembled vector; must match downstream and_tree N; N >= 1
W, 2, input chunk width; 1 <= W <= N
CHUNKS, derived = ceil(N/W), chunks per full frame; not overridable

Ports:
clk  input  1  clock, all logic rising-edge
rst  input  1  reset, synchronous, active-high
in_valid  input  1  chunk present on in_data
in_ready  output  1  feeder can accept chunk
in_data  input  W  chunk; in_data[b] maps to x[k*W+b] for chunk index k
in_last  input  1  qualifies chunk as final chunk of frame
out_valid  output  1  x holds a complete frame
out_ready  input  1  downstream accepts x
x  output  [0:N-1]  assembled vector, ascending index as consumed by and_tree
out_short  output  1  frame was closed by in_last before CHUNKS chunks; valid with out_valid

Behaviour:
- Reset (synchronous, active-high; clk and rst are the only clock/reset):
  - x = all 1s, out_valid = 0, out_short = 0, count = 0, state = FILL.
  - rst mid-frame discards the partial frame; rst during HOLD drops the pending frame.
- State FILL:
  - in_ready = 1, out_valid = 0.
  - An accept is in_valid & in_ready. On accept, chunk k = count is written into x[k*W .. k*W+W-1].
  - Final chunk when N % W != 0: only in_data[0 .. N-(CHUNKS-1)*W-1] is used; upper bits are ignored.
  - count increments on each accept.
- Frame close, evaluated on an accept:
  - Close when in_last = 1 or count == CHUNKS-1.
  - Next cycle: state = HOLD, out_valid = 1.
  - out_short = in_last & (count < CHUNKS-1).
  - in_last on the CHUNKS-th chunk is a normal close with out_short = 0.
  - Reaching CHUNKS chunks without in_last closes the frame anyway. The next chunk starts a new frame; there is no error flag.
- Padding: bits not written in a short frame keep their preloaded value of 1.
- State HOLD:
  - in_ready = 0 (unless the optional feature is enabled).
  - x and out_short are stable while out_valid & !out_ready.
  - On out_valid & out_ready: state = FILL, x = all 1s, count = 0, out_valid = 0 next cycle.
- Latency:
  - out_valid rises 1 cycle after the closing chunk is accepted.
  - Minimum frame period is CHUNKS+1 cycles.
- x never changes in HOLD. In FILL, x is don't-care to downstream because out_valid = 0.
- Counter width is $clog2(CHUNKS+1). count never exceeds CHUNKS-1 in FILL.
- N == W, or W == N == 1: single-chunk frames, each closes immediately, and out_short is always 0.

Optional Feature:
- Macro: AND_TREE_FEEDER_OVERLAP_EN.
- Defined:
  - in_ready = FILL | (HOLD & out_ready).
  - A chunk accepted in the same cycle as the output handshake becomes chunk 0 of the next frame. It is written into a freshly all-1s vector, and count = 1.
  - If that chunk also closes the frame (in_last or CHUNKS == 1), the next state is HOLD with out_valid held at 1, giving back-to-back frames.
  - Sustained throughput is one frame per CHUNKS cycles.
- Undefined: in_ready = 0 throughout HOLD, as described above.

Test Plan:
- N=8,W=2: chunks 2'b11 x4, no in_last, out_ready=1 -> out_valid 1 cycle after 4th accept, x=8'b11111111, out_short=0, out_valid low next cycle.
- N=8,W=2: chunks 2'b01, 2'b10 (with in_last) -> x[0:7]=1,0,0,1,1,1,1,1; out_short=1; downstream and_tree y=0.
- N=5,W=2: chunks 2'b11, 2'b11, 2'b11 -> x=5'b11111, frame closes on 3rd chunk, out_short=0; the 3rd chunk's bit 1 is ignored (check that driving it 0 still gives all 1s).
- Backpressure: complete frame, hold out_ready=0 for 6 cycles while in_valid=1 -> in_ready=0, x and out_short unchanged; out_ready=1 -> handshake and return to FILL.
- rst asserted after 2 of 4 chunks -> next cycle out_valid=0, x all 1s, count=0; a full new frame of 2'b00 x4 then gives x=8'b00000000.
- With AND_TREE_FEEDER_OVERLAP_EN, N=W=2: in_valid=1 continuously with in_last=1, out_ready=1 -> out_valid stays 1 every cycle after the first, with one frame per cycle.

Source files
------------

// File: rtl/and_tree_feeder_if.sv
// and_tree_feeder_if: stream-in / vector-out handshake bundle between the chunk source, the feeder and and_tree
interface and_tree_feeder_if #(parameter int N = 8, parameter int W = 2);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [0:N-1] x;
  logic         out_short;
  modport master (output in_valid, in_data, in_last, out_ready, input in_ready, out_valid, x, out_short);
  modport slave (input in_valid, in_data, in_last, out_ready, output in_ready, out_valid, x, out_short);
endinterface

// File: rtl/and_tree_feeder.sv
// and_tree_feeder: packs W-bit chunks into a 1-padded N-bit vector x[0:N-1] for and_tree.
// Ports: clk, rst (sync, active-high); bus.in_valid/in_ready/in_data/in_last chunk stream in,
// bus.out_valid/out_ready/x/out_short frame out. Define AND_TREE_FEEDER_OVERLAP_EN to accept
// the first chunk of the next frame in the same cycle as the output handshake.
module and_tree_feeder #(
  parameter int N = 8,
  parameter int W = 2
) (
  input logic clk,
  input logic rst,
  and_tree_feeder_if.slave bus
);
  localparam int CHUNKS = (N + W - 1) / W;
  localparam int CW = $clog2(CHUNKS + 1);
  typedef enum logic {FILL, HOLD} state_t;
  state_t state;
  logic [CW-1:0] count, k;
  logic [0:N-1] x_wr;
  logic acc, fire, close;
`ifdef AND_TREE_FEEDER_OVERLAP_EN
  assign bus.in_ready = state == FILL || bus.out_ready;
`else
  assign bus.in_ready = state == FILL;
`endif
  assign fire = bus.out_valid & bus.out_ready;
  assign acc = bus.in_valid & bus.in_ready;
  // a chunk arriving with the handshake starts a fresh frame at index 0
  assign k = fire ? '0 : count;
  assign close = acc & (bus.in_last | k == CW'(CHUNKS - 1));
  // bits past N in the final chunk have no slot and are dropped
  always_comb begin
    for (int b = 0; b < N; b++)
      x_wr[b] = acc && k == CW'(b / W) ? bus.in_data[b % W] : fire ? 1'b1 : bus.x[b];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
      bus.out_valid <= 1'b0;
      bus.out_short <= 1'b0;
      bus.x <= '1;
      count <= '0;
    end else begin
      bus.x <= x_wr;
      count <= close ? '0 : acc ? k + 1'b1 : fire ? '0 : count;
      if (close) begin
        state <= HOLD;
        bus.out_valid <= 1'b1;
        bus.out_short <= bus.in_last & (k < CW'(CHUNKS - 1));
      end else if (fire) begin
        state <= FILL;
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_and_tree_feeder.sv
// tb_and_tree_feeder: directed vectors for and_tree_feeder (N=8/W=2, N=5/W=2, overlap N=W=2)
module tb_and_tree_feeder;
  logic clk = 1'b0;
  logic rst;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  and_tree_feeder_if #(.N(8), .W(2)) a ();
  and_tree_feeder_if #(.N(5), .W(2)) b ();
  and_tree_feeder #(.N(8), .W(2)) dut_a (.clk(clk), .rst(rst), .bus(a.slave));
  and_tree_feeder #(.N(5), .W(2)) dut_b (.clk(clk), .rst(rst), .bus(b.slave));
`ifdef AND_TREE_FEEDER_OVERLAP_EN
  and_tree_feeder_if #(.N(2), .W(2)) c ();
  and_tree_feeder #(.N(2), .W(2)) dut_c (.clk(clk), .rst(rst), .bus(c.slave));
`endif
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send_a(input logic [1:0] d, input logic last);
    a.in_valid = 1'b1;
    a.in_data = d;
    a.in_last = last;
    @(negedge clk);
    a.in_valid = 1'b0;
    a.in_last = 1'b0;
  endtask
  task automatic handshake_a();
    a.out_ready = 1'b1;
    @(negedge clk);
    a.out_ready = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    a.in_valid = 1'b0; a.in_data = '0; a.in_last = 1'b0; a.out_ready = 1'b0;
    b.in_valid = 1'b0; b.in_data = '0; b.in_last = 1'b0; b.out_ready = 1'b0;
`ifdef AND_TREE_FEEDER_OVERLAP_EN
    c.in_valid = 1'b0; c.in_data = '0; c.in_last = 1'b0; c.out_ready = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(a.out_valid), 0);
    chk("rst_x", 32'(a.x), 32'hff);
    chk("rst_short", 32'(a.out_short), 0);
    chk("rst_ready", 32'(a.in_ready), 1);
    rst = 1'b0;
    // full frame of 11s, no in_last
    for (int i = 0; i < 4; i++) begin
      chk("full_pre_valid", 32'(a.out_valid), 0);
      send_a(2'b11, 1'b0);
    end
    chk("full_valid", 32'(a.out_valid), 1);
    chk("full_x", 32'(a.x), 32'hff);
    chk("full_short", 32'(a.out_short), 0);
    chk("full_hold_ready", 32'(a.in_ready), 0);
    handshake_a();
    chk("full_after_valid", 32'(a.out_valid), 0);
    chk("full_after_ready", 32'(a.in_ready), 1);
    // short frame: x[0:7]=1,0,0,1,1,1,1,1
    send_a(2'b01, 1'b0);
    send_a(2'b10, 1'b1);
    chk("short_valid", 32'(a.out_valid), 1);
    chk("short_x", 32'(a.x), 32'h9f);
    chk("short_flag", 32'(a.out_short), 1);
    chk("short_and_y", 32'(&a.x), 0);
    handshake_a();
    // in_last on the 4th chunk is a normal close
    send_a(2'b11, 1'b0);
    send_a(2'b11, 1'b0);
    send_a(2'b11, 1'b0);
    send_a(2'b01, 1'b1);
    chk("last4_x", 32'(a.x), 32'hfe);
    chk("last4_short", 32'(a.out_short), 0);
    handshake_a();
    // backpressure with in_valid held high
    send_a(2'b00, 1'b0);
    send_a(2'b11, 1'b0);
    send_a(2'b01, 1'b0);
    send_a(2'b10, 1'b0);
    a.in_valid = 1'b1;
    a.in_data = 2'b00;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("bp_ready", 32'(a.in_ready), 0);
      chk("bp_valid", 32'(a.out_valid), 1);
      chk("bp_x", 32'(a.x), 32'h39);
      chk("bp_short", 32'(a.out_short), 0);
    end
    a.in_valid = 1'b0;
    handshake_a();
    chk("bp_release_valid", 32'(a.out_valid), 0);
    chk("bp_release_x", 32'(a.x), 32'hff);
    // reset mid-frame discards partial data
    send_a(2'b00, 1'b0);
    send_a(2'b00, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_valid", 32'(a.out_valid), 0);
    chk("midrst_x", 32'(a.x), 32'hff);
    for (int i = 0; i < 4; i++) begin
      chk("midrst_pre_valid", 32'(a.out_valid), 0);
      send_a(2'b00, 1'b0);
    end
    chk("midrst_full_valid", 32'(a.out_valid), 1);
    chk("midrst_full_x", 32'(a.x), 32'h00);
    handshake_a();
    // N=5: 3rd chunk bit 1 has no slot
    b.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("n5_pre_valid", 32'(b.out_valid), 0);
      b.in_valid = 1'b1;
      b.in_data = i == 2 ? 2'b01 : 2'b11;
      @(negedge clk);
    end
    b.in_valid = 1'b0;
    chk("n5_valid", 32'(b.out_valid), 1);
    chk("n5_x", 32'(b.x), 32'h1f);
    chk("n5_short", 32'(b.out_short), 0);
    @(negedge clk);
    chk("n5_after_valid", 32'(b.out_valid), 0);
`ifdef AND_TREE_FEEDER_OVERLAP_EN
    c.in_valid = 1'b1;
    c.in_last = 1'b1;
    c.out_ready = 1'b1;
    c.in_data = 2'b01;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("ovl_valid", 32'(c.out_valid), 1);
      chk("ovl_ready", 32'(c.in_ready), 1);
      chk("ovl_x", 32'(c.x), c.in_data == 2'b01 ? 32'h2 : 32'h1);
      c.in_data = c.in_data == 2'b01 ? 2'b10 : 2'b01;
      @(negedge clk);
    end
    c.in_valid = 1'b0;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
